// File: rtl/role_chaser.sv
// Sprite that chases a target on a VGA playfield, with a sprite ROM address/key generator.
// Define ROLE_CHASER_STUN_EN to build the hit-driven STUN state; without it hit is ignored.
module role_chaser #(
  parameter int          SPAWN_X     = 600,
  parameter int          SPAWN_Y     = 440,
  parameter int          ZONE_Y_MIN  = 297,
  parameter int          TIME_MAX    = 4600000,
  parameter int          SPR_W       = 32,
  parameter int          FRAMES      = 2,
  parameter int          FRAME_TICKS = 20000000,
  parameter int          STUN_STEPS  = 64,
  parameter logic [11:0] KEY_RGB     = 12'h1F0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [9:0]                              target_x,
  input  logic [9:0]                              target_y,
  input  logic [9:0]                              x,
  input  logic [9:0]                              y,
  input  logic [25:0]                             speed_offset,
  input  logic                                    hit,
  input  logic [11:0]                             rom_data,
  output logic [$clog2(FRAMES*SPR_W*SPR_W)-1:0]   rom_addr,
  output logic [9:0]                              pos_x,
  output logic [9:0]                              pos_y,
  output logic [1:0]                              state,
  output logic                                    sprite_on,
  output logic [11:0]                             rgb_out
);
  localparam int LW = $clog2(SPR_W);
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int AW = $clog2(FRAMES*SPR_W*SPR_W);
  localparam logic [9:0]    X_MAX   = 10'(640 - SPR_W);
  localparam logic [9:0]    Y_MAX   = 10'(480 - SPR_W);
  localparam logic [9:0]    ZONE    = 10'(ZONE_Y_MIN);
  localparam logic [31:0]   TMAX    = 32'(TIME_MAX);
  localparam logic [31:0]   FT_LAST = 32'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] FR_LAST = FW'(FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_CHASE = 2'b01, S_STUN = 2'b10} state_t;

  state_t        state_q, state_d;
  logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic          facing_q, facing_d;   // 1 = LEFT
  logic [31:0]   tcnt_q, tcnt_d, ftick_q, ftick_d, period;
  logic [FW-1:0] frame_q, frame_d;
  logic          inbox_q, inbox_d;
  logic          tick, zone_in;
  logic [LW-1:0] row, col_raw, col;

`ifdef ROLE_CHASER_STUN_EN
  localparam int SW = (STUN_STEPS > 1) ? $clog2(STUN_STEPS) : 1;
  localparam logic [SW-1:0] STUN_LAST = SW'(STUN_STEPS - 1);
  logic [SW-1:0] stun_cnt_q, stun_cnt_d;
`else
  logic unused_hit;
  assign unused_hit = hit;
`endif

  always_comb begin
    // A period shrunk below the running count wraps the counter instead of letting it run away.
    period  = ({6'd0, speed_offset} >= TMAX) ? 32'd1 : TMAX - {6'd0, speed_offset};
    tick    = (tcnt_q == period);
    tcnt_d  = (tcnt_q >= period) ? 32'd0 : tcnt_q + 32'd1;
    zone_in = (target_y >= ZONE);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (zone_in)  state_d = S_CHASE;
      S_CHASE: if (!zone_in) state_d = S_IDLE;
`ifdef ROLE_CHASER_STUN_EN
      S_STUN:  if (tick && stun_cnt_q == STUN_LAST) state_d = zone_in ? S_CHASE : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef ROLE_CHASER_STUN_EN
    stun_cnt_d = stun_cnt_q;
    if (state_q == S_STUN && tick) stun_cnt_d = (stun_cnt_q == STUN_LAST) ? '0 : stun_cnt_q + 1'b1;
    if (hit) begin
      state_d    = S_STUN;
      stun_cnt_d = '0;
    end
`endif

    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (tick && state_q == S_CHASE) begin
      if (target_x > pos_x_q && pos_x_q < X_MAX)      pos_x_d = pos_x_q + 10'd1;
      else if (target_x < pos_x_q && pos_x_q != '0)   pos_x_d = pos_x_q - 10'd1;
      if (target_y > pos_y_q && pos_y_q < Y_MAX)      pos_y_d = pos_y_q + 10'd1;
      else if (target_y < pos_y_q && pos_y_q != '0)   pos_y_d = pos_y_q - 10'd1;
    end
`ifdef ROLE_CHASER_STUN_EN
    else if (tick && state_q == S_STUN) begin
      if (target_x > pos_x_q && pos_x_q != '0)        pos_x_d = pos_x_q - 10'd1;
      else if (target_x < pos_x_q && pos_x_q < X_MAX) pos_x_d = pos_x_q + 10'd1;
    end
`endif

    facing_d = facing_q;
    if (target_x > pos_x_q)      facing_d = 1'b0;
    else if (target_x < pos_x_q) facing_d = 1'b1;

    ftick_d = '0;
    frame_d = '0;
    if (state_q == S_CHASE) begin
      if (ftick_q == FT_LAST) frame_d = (frame_q == FR_LAST) ? '0 : frame_q + 1'b1;
      else begin
        ftick_d = ftick_q + 32'd1;
        frame_d = frame_q;
      end
    end

    inbox_d = ({1'b0, x} >= {1'b0, pos_x_q}) && ({1'b0, x} < {1'b0, pos_x_q} + 11'(SPR_W)) &&
              ({1'b0, y} >= {1'b0, pos_y_q}) && ({1'b0, y} < {1'b0, pos_y_q} + 11'(SPR_W));
    row     = LW'(y - pos_y_q);
    col_raw = LW'(x - pos_x_q);
    col     = facing_q ? ~col_raw : col_raw;   // SPR_W-1-col for a power-of-two edge
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pos_x_q  <= 10'(SPAWN_X);
      pos_y_q  <= 10'(SPAWN_Y);
      facing_q <= 1'b0;
      tcnt_q   <= '0;
      ftick_q  <= '0;
      frame_q  <= '0;
      inbox_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      facing_q <= facing_d;
      tcnt_q   <= tcnt_d;
      ftick_q  <= ftick_d;
      frame_q  <= frame_d;
      inbox_q  <= inbox_d;
    end
  end

`ifdef ROLE_CHASER_STUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stun_cnt_q <= '0;
    else       stun_cnt_q <= stun_cnt_d;
  end
`endif

  assign rom_addr  = AW'({frame_q, row, col});
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign state     = state_q;
  assign sprite_on = inbox_q && (rom_data != KEY_RGB);
  assign rgb_out   = rom_data;
endmodule

// File: tb/tb_role_chaser.sv
// Directed bench for role_chaser: chase timing, idle hold, fast period, stun/hit, sprite addressing.
module tb_role_chaser;
  localparam int TIME_MAX = 4600000;
  localparam logic [11:0] KEY = 12'h1F0;

  logic        clk, reset, hit, sprite_on;
  logic [9:0]  target_x, target_y, x, y, pos_x, pos_y;
  logic [25:0] speed_offset;
  logic [11:0] rom_data, rgb_out;
  logic [10:0] rom_addr;
  logic [1:0]  state;
  int          errors = 0;
  int          checks = 0;

  role_chaser #(.FRAME_TICKS(8), .STUN_STEPS(4)) dut (
    .clk(clk), .reset(reset), .target_x(target_x), .target_y(target_y),
    .x(x), .y(y), .speed_offset(speed_offset), .hit(hit), .rom_data(rom_data),
    .rom_addr(rom_addr), .pos_x(pos_x), .pos_y(pos_y), .state(state),
    .sprite_on(sprite_on), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; hit = 1'b0; rom_data = 12'h000;
    target_x = 10'd100; target_y = 10'd400; x = 10'd0; y = 10'd0;
    speed_offset = 26'(TIME_MAX - 10);
    #1;
    check("rst_pos_x", 32'(pos_x), 600);
    check("rst_pos_y", 32'(pos_y), 440);
    check("rst_state", 32'(state), 0);
    check("rst_sprite_on", 32'(sprite_on), 0);
    step(2); reset = 1'b0;

    // period 10: first step lands on the 11th edge
    step(1);  check("chase_enter", 32'(state), 1);
    step(9);  check("pre_tick_x", 32'(pos_x), 600);
    step(1);  check("tick_x", 32'(pos_x), 599);
              check("tick_y", 32'(pos_y), 439);

    // pixel at the sprite origin, facing left, frame 1
    x = 10'd599; y = 10'd439; rom_data = KEY; #1;
    check("addr_mirror_f1", 32'(rom_addr), 1055);
    step(1);  check("key_transparent", 32'(sprite_on), 0);
    rom_data = 12'hABC; #1;
    check("opaque_on", 32'(sprite_on), 1);
    x = 10'd604; y = 10'd442; #1;
    check("addr_row3_col5", 32'(rom_addr), 1146);
    x = 10'd598; target_y = 10'd200;
    step(1);  check("outside_box", 32'(sprite_on), 0);
              check("idle_enter", 32'(state), 0);

    step(1100);
    check("idle_hold_x", 32'(pos_x), 599);
    check("idle_hold_y", 32'(pos_y), 439);
    check("idle_state", 32'(state), 0);
    x = 10'd599; y = 10'd439; #1;
    check("idle_frame0", 32'(rom_addr), 31);

    // offset past TIME_MAX clamps period to 1; count 2 wraps to 0 first
    speed_offset = 26'(TIME_MAX + 5); target_y = 10'd400;
    step(1);  check("fast_chase", 32'(state), 1);
              check("fast_wrap_x", 32'(pos_x), 599);
    step(2);  check("fast_first_x", 32'(pos_x), 598);
    step(1);  check("fast_odd_x", 32'(pos_x), 598);
    step(16); check("fast_run_x", 32'(pos_x), 590);
              check("fast_run_y", 32'(pos_y), 430);

    target_x = 10'd0;
    step(1200);
    check("clamp_lo_x", 32'(pos_x), 0);
    check("settle_y", 32'(pos_y), 400);

    step(1);
    hit = 1'b1; target_x = 10'd700;
`ifdef ROLE_CHASER_STUN_EN
    step(1);  hit = 1'b0;
              check("stun_enter", 32'(state), 2);
    step(6);  check("stun_hold_state", 32'(state), 2);
              check("stun_clamp_x", 32'(pos_x), 0);
    step(1);  check("stun_exit", 32'(state), 1);
    step(2);  check("post_stun_x", 32'(pos_x), 1);
    hit = 1'b1;
    step(1);  hit = 1'b0;
              check("stun2_enter", 32'(state), 2);
    step(3);  hit = 1'b1;
    step(1);  hit = 1'b0;
    step(6);  check("restart_hold", 32'(state), 2);
              check("restart_x", 32'(pos_x), 0);
    step(1);  check("restart_exit", 32'(state), 1);
`else
    step(1);  hit = 1'b0;
              check("hit_ignored", 32'(state), 1);
    step(1);  check("hit_motion_x", 32'(pos_x), 1);
              check("hit_state", 32'(state), 1);
`endif

    target_y = 10'd479;
    step(1400);
    check("clamp_hi_x", 32'(pos_x), 608);
    check("clamp_hi_y", 32'(pos_y), 448);
    check("hi_state", 32'(state), 1);
    x = 10'd608; y = 10'd448; rom_data = 12'hABC; #1;
    check("right_col0", 32'(rom_addr[9:0]), 0);
    x = 10'd639; y = 10'd479; #1;
    check("right_col31", 32'(rom_addr[9:0]), 1023);
    step(1);  check("edge_on", 32'(sprite_on), 1);

    reset = 1'b1; #1;
    check("midrst_x", 32'(pos_x), 600);
    check("midrst_y", 32'(pos_y), 440);
    check("midrst_state", 32'(state), 0);
    check("midrst_sprite", 32'(sprite_on), 0);
    step(2); reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/role_chaser.md
ROLE_CHASER -- requirements
Module: role_chaser

Interface
REQ-001 SHALL have parameter SPAWN_X, 600, reset x position (pixels).
REQ-002 SHALL have parameter SPAWN_Y, 440, reset y position (pixels).
REQ-003 SHALL have parameter ZONE_Y_MIN, 297, minimum target_y that activates chasing.
REQ-004 SHALL have parameter TIME_MAX, 4600000, base step period (clk cycles).
REQ-005 SHALL have parameter SPR_W, 32, sprite edge in pixels (power of two, 8..64).
REQ-006 SHALL have parameter FRAMES, 2, animation frame count (1..8).
REQ-007 SHALL have parameter FRAME_TICKS, 20000000, clk cycles per animation frame.
REQ-008 SHALL have parameter STUN_STEPS, 64, step ticks spent stunned after a hit.
REQ-009 SHALL have parameter KEY_RGB, 12'h1F0, transparent colour.
REQ-010 SHALL have port clk  input  1  clock.
REQ-011 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-012 SHALL have port target_x, target_y  input  10 each  chased object position.
REQ-013 SHALL have port x, y  input  10 each  current VGA pixel.
REQ-014 SHALL have port speed_offset  input  26  subtracted from TIME_MAX.
REQ-015 SHALL have port hit  input  1  single-cycle hit pulse.
REQ-016 SHALL have port rom_data  input  12  sprite ROM output, 1-cycle read latency.
REQ-017 SHALL have port rom_addr  output  log2(FRAMES*SPR_W*SPR_W)  sprite ROM address.
REQ-018 SHALL have ports pos_x, pos_y  output  10 each  current position.
REQ-019 SHALL have port state  output  2  00 IDLE, 01 CHASE, 10 STUN.
REQ-020 SHALL have port sprite_on  output  1  opaque sprite pixel present.
REQ-021 SHALL have port rgb_out  output  12  pixel colour (equals rom_data).

Function
REQ-022 SHALL be fully synchronous to clk; no derived clocks; step logic SHALL use a one-cycle tick enable.
REQ-023 Tick counter SHALL count 0..P and pulse tick when it equals P, where P = TIME_MAX-speed_offset, clamped to 1 if speed_offset >= TIME_MAX; a change of P below the current count SHALL wrap the counter to 0 next cycle.
REQ-024 FSM: IDLE->CHASE when target_y >= ZONE_Y_MIN; CHASE->IDLE when target_y < ZONE_Y_MIN; CHASE or IDLE->STUN on hit; STUN->CHASE or IDLE (per zone test) after STUN_STEPS ticks.
REQ-025 In CHASE on tick, each axis SHALL move 1 pixel toward target (no move when equal).
REQ-026 In IDLE, position SHALL hold.
REQ-027 In STUN on tick, x SHALL move 1 pixel away from target_x (hold when equal); y holds.
REQ-028 Position SHALL be clamped to x in 0..640-SPR_W, y in 0..480-SPR_W; no wrap-around.
REQ-029 hit during STUN SHALL restart the stun count; hit coincident with tick SHALL enter STUN and the tick SHALL apply STUN motion starting next tick.
REQ-030 Facing SHALL be RIGHT when target_x > pos_x, LEFT when target_x < pos_x, held when equal; LEFT mirrors column (SPR_W-1-col).
REQ-031 Frame counter SHALL advance every FRAME_TICKS cycles modulo FRAMES, only in CHASE; forced to 0 in IDLE and STUN.
REQ-032 rom_addr SHALL be (frame*SPR_W + row)*SPR_W + col, row = y-pos_y, col per REQ-030, computed combinationally from x, y.
REQ-033 sprite_on SHALL be the in-box flag (pos <= pixel < pos+SPR_W on both axes) delayed one cycle, ANDed with rom_data != KEY_RGB.

Reset
REQ-034 On reset: pos_x=SPAWN_X, pos_y=SPAWN_Y, state=IDLE, facing RIGHT, tick counter, frame, stun count all 0, delayed in-box flag 0 (sprite_on=0).
REQ-035 Reset asserted mid-chase or mid-stun SHALL take effect immediately and abandon all motion.

Configuration
REQ-036 Macro ROLE_CHASER_STUN_EN: defined -> STUN state and hit behaviour per REQ-024/027/029; undefined -> hit ignored, STUN unreachable, state never 10, stun counter not implemented.

Verification
REQ-037 Reset, target (100,400), speed_offset=TIME_MAX-10 -> state CHASE; pos_x 600->599 after 11 cycles; pos_y 440->439.
REQ-038 target_y=200 -> state IDLE, pos unchanged over 100 ticks, frame=0.
REQ-039 pos_x=0, target_x=700 while stunned (STUN_STEPS=4) -> pos_x stays 0, returns to CHASE after 4 ticks; hit at tick 2 -> 4 more ticks.
REQ-040 speed_offset=TIME_MAX+5 -> tick every 2 cycles, no hang.
REQ-041 Pixel (pos_x,pos_y) with facing LEFT, frame 1, SPR_W=32 -> rom_addr=1*1024+31; rom_data=KEY_RGB -> sprite_on=0 next cycle; other value -> 1.
REQ-042 Build without ROLE_CHASER_STUN_EN, pulse hit -> state stays CHASE, motion unchanged.
